// File: rtl/pgr_uart_rx_fifo_pkg.sv
// Shared receiver state encoding and baud-divider derivation for the
// UART receive path.
package pgr_uart_rx_fifo_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Clock cycles per serial bit, truncated; clk_mhz is in MHz.
   function automatic int unsigned calc_bit_div(input int unsigned clk_mhz,
                                                input int unsigned baud);
      return (clk_mhz * 32'd1000000) / baud;
   endfunction

   function automatic int unsigned calc_half_div(input int unsigned clk_mhz,
                                                 input int unsigned baud);
      return calc_bit_div(clk_mhz, baud) / 32'd2;
   endfunction

endpackage

// File: rtl/pgr_sync_fifo.sv
// Single-clock FIFO with an exact occupancy count and a registered read port
// that holds its last value between reads.
module pgr_sync_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   cnt
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          wr_ok, rd_ok;

   always_comb begin
      full      = (cnt_q == (AW+1)'(DEPTH));
      wr_ok     = wr_en & ~full;
      rd_ok     = rd_en & (cnt_q != '0);
      wr_ptr_d  = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      rd_data_d = rd_ok ? mem[rd_ptr_q] : rd_data_q;
      cnt_d     = cnt_q;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data;
   end

   assign cnt     = cnt_q;
   assign rd_data = rd_data_q;

endmodule

// File: rtl/pgr_uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a FIFO that the command
// parser drains one byte per request.
module pgr_uart_rx_fifo
   import pgr_uart_rx_fifo_pkg::*;
#(
   parameter logic [7:0]  CLK_FREQ  = 8'd50,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             uart_rx,
   output logic [7:0]       rx_fifo_rd_data,
   output logic             rx_fifo_rd_data_valid,
   input  logic             rx_fifo_rd_data_req,
   output logic [FIFO_AW:0] fifo_cnt,
   output logic             frame_err,
   output logic             overflow
);

   localparam int unsigned BIT_DIV  = calc_bit_div(32'(CLK_FREQ), BAUD_RATE);
   localparam int unsigned HALF_DIV = calc_half_div(32'(CLK_FREQ), BAUD_RATE);
   localparam int unsigned CW       = $clog2(BIT_DIV + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

   logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic [1:0]    settle_q, settle_d;
   logic          armed_q, armed_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_err_q, frame_err_d;
   logic          overflow_q, overflow_d;
   logic          rd_valid_q, rd_valid_d;
   logic          wr_req, wr_full, rd_en;

   always_comb begin
      rx_s1_d   = uart_rx;
      rx_s2_d   = rx_s1_q;
      rx_prev_d = rx_s2_q;
      // Edges count only once the synchronizer holds real line samples and
      // the line has been seen idle, so a line held low through reset is ignored.
      settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      armed_d   = armed_q | ((settle_q == 2'd2) & rx_s2_q);

      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q + CW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      wr_req      = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            if (armed_q & rx_prev_q & ~rx_s2_q) state_d = ST_START;
         end
         ST_START: begin
            if (baud_cnt_q == HALF_LAST) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = rx_s2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = '0;
               shift_d    = {rx_s2_q, shift_q[7:1]};
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d  = '0;
               state_d     = ST_IDLE;
               wr_req      = rx_s2_q;
               frame_err_d = ~rx_s2_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      overflow_d = wr_req & wr_full;
      rd_en      = rx_fifo_rd_data_req & (fifo_cnt != '0);
      rd_valid_d = rd_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         rx_s1_q     <= rx_s1_d;
         rx_s2_q     <= rx_s2_d;
         rx_prev_q   <= rx_prev_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   pgr_sync_fifo #(
      .DW(8),
      .AW(FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_req),
      .wr_data (shift_q),
      .full    (wr_full),
      .rd_en   (rd_en),
      .rd_data (rx_fifo_rd_data),
      .cnt     (fifo_cnt)
   );

   assign rx_fifo_rd_data_valid = rd_valid_q;
   assign frame_err             = frame_err_q;
   assign overflow              = overflow_q;

endmodule

// File: tb/tb_pgr_uart_rx_fifo.sv
// Bench for pgr_uart_rx_fifo: serial frames driven bit by bit, a queue model
// of the FIFO, table vectors, directed corner cases and random traffic.
module tb_pgr_uart_rx_fifo;
   import pgr_uart_rx_fifo_pkg::*;

   localparam int unsigned CLK_MHZ = 40;
   localparam int unsigned BAUD    = 1000000;
   localparam int unsigned AW      = 4;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned BD      = (CLK_MHZ * 1000000) / BAUD;
   localparam int unsigned H       = BD / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_rx = 1'b1;
   logic          req = 1'b0;
   logic [7:0]    rd_data;
   logic          valid, ferr, ovf;
   logic [AW:0]   cnt;

   always #5 clk = ~clk;

   pgr_uart_rx_fifo #(
      .CLK_FREQ  (8'd40),
      .BAUD_RATE (BAUD),
      .FIFO_AW   (AW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .uart_rx               (uart_rx),
      .rx_fifo_rd_data       (rd_data),
      .rx_fifo_rd_data_valid (valid),
      .rx_fifo_rd_data_req   (req),
      .fifo_cnt              (cnt),
      .frame_err             (ferr),
      .overflow              (ovf)
   );

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         exp_ferr;
      int         exp_cnt;
   } vec_t;

   int         n_vec = 0, n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_exp = 8'h00;
   int         exp_ferr = 0, exp_ovf = 0;
   int         obs_ferr = 0, obs_ovf = 0;
   int         ferr_base = 0, ovf_base = 0;
   logic       prev_ferr = 1'b0, prev_ovf = 1'b0;
   logic       stop_valid, stop_ovf;
   logic [7:0] stop_data;
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Read side of the scoreboard: every valid byte must be the model's head.
   always @(negedge clk) begin
      if (rst) begin
         last_exp = 8'h00;
      end else begin
         if (valid) begin
            if (exp_q.size() == 0) check("valid_from_empty", 1, 0);
            else begin
               last_exp = exp_q.pop_front();
               check("rd_data", rd_data, last_exp);
            end
         end
         if (ferr) begin
            obs_ferr++;
            check("frame_err_width", prev_ferr, 0);
         end
         if (ovf) begin
            obs_ovf++;
            check("overflow_width", prev_ovf, 0);
         end
      end
      prev_ferr = ferr;
      prev_ovf  = ovf;
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit req_at_stop);
      uart_rx = 1'b0;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(BD);
      end
      uart_rx = stop_ok;
      // Now in the cycle where the receiver samples the stop bit.
      tick(H + 2);
      if (stop_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovf++;
      end else begin
         exp_ferr++;
      end
      if (req_at_stop) begin
         req = 1'b1;
         tick(1);
         req = 1'b0;
         stop_valid = valid;
         stop_ovf   = ovf;
         stop_data  = rd_data;
         tick(BD - H - 3);
      end else begin
         tick(BD - H - 2);
      end
      uart_rx = 1'b1;
      if (!stop_ok) tick(BD);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      check("rst_rd_data", rd_data, 0);
      check("rst_valid", valid, 0);
      check("rst_frame_err", ferr, 0);
      check("rst_overflow", ovf, 0);
      check("rst_fifo_cnt", cnt, 0);
      exp_q.delete();
      exp_ferr  = 0;
      exp_ovf   = 0;
      ferr_base = obs_ferr;
      ovf_base  = obs_ovf;
      rst = 1'b0;
      tick(5);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_cnt"}, cnt, exp_q.size());
      check({tag, "_ferr"}, obs_ferr - ferr_base, exp_ferr);
      check({tag, "_ovf"}, obs_ovf - ovf_base, exp_ovf);
   endtask

   task automatic drain(input string tag);
      req = 1'b1;
      tick(DEPTH + 2);
      req = 1'b0;
      tick(2);
      check({tag, "_drain_cnt"}, cnt, 0);
      check({tag, "_drain_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] rb;
      bit         rok;
      int         nrd;

      vecs[0] = '{8'h55, 1'b1, 0, 1};
      vecs[1] = '{8'hA3, 1'b0, 1, 1};
      vecs[2] = '{8'h3C, 1'b1, 0, 2};
      vecs[3] = '{8'h00, 1'b1, 0, 3};
      vecs[4] = '{8'hFF, 1'b1, 0, 4};
      vecs[5] = '{8'h80, 1'b0, 1, 4};
      vecs[6] = '{8'h01, 1'b1, 0, 5};
      vecs[7] = '{8'hC7, 1'b1, 0, 6};

      check("bit_div_default", calc_bit_div(50, 115200), 434);
      check("half_div_default", calc_half_div(50, 115200), 217);

      do_reset();

      // Single 0x55 frame, one read.
      send_frame(8'h55, 1'b1, 1'b0);
      check("r55_cnt_before", cnt, 1);
      req = 1'b1;
      tick(1);
      req = 1'b0;
      check("r55_valid", valid, 1);
      check("r55_data", rd_data, 8'h55);
      check("r55_cnt_after", cnt, 0);
      tick(1);
      check("r55_valid_drop", valid, 0);
      check("r55_hold", rd_data, 8'h55);

      // Short low glitch from idle is rejected.
      uart_rx = 1'b0;
      tick(H / 2);
      uart_rx = 1'b1;
      tick(3 * BD);
      check_status("glitch");

      for (int v = 0; v < 8; v++) begin
         int f0;
         f0 = obs_ferr;
         send_frame(vecs[v].data, vecs[v].stop_ok, 1'b0);
         check("vec_ferr", obs_ferr - f0, vecs[v].exp_ferr);
         check("vec_cnt", cnt, vecs[v].exp_cnt);
      end
      drain("table");

      // 17 back-to-back frames, the last one overflows.
      do_reset();
      for (int b = 0; b < 17; b++) begin
         if (b == 16) check("ovf_before_last", obs_ovf - ovf_base, 0);
         send_frame(8'(b), 1'b1, 1'b0);
      end
      check("full_cnt", cnt, 16);
      check("full_ovf", obs_ovf - ovf_base, 1);
      req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         check("burst_valid", valid, 1);
         check("burst_data", rd_data, i);
      end
      tick(1);
      check("empty_req_valid", valid, 0);
      req = 1'b0;
      tick(1);
      check("burst_cnt", cnt, 0);

      // Full FIFO, read in the same cycle as the stop-bit write.
      do_reset();
      for (int i = 0; i < 16; i++) send_frame(8'hB0 + 8'(i), 1'b1, 1'b0);
      send_frame(8'h77, 1'b1, 1'b1);
      check("collide_valid", stop_valid, 1);
      check("collide_ovf", stop_ovf, 1);
      check("collide_head", stop_data, 8'hB0);
      check("collide_cnt", cnt, 15);
      check_status("collide");
      drain("collide");

      // Reset during bit 4 of a 0xFF frame discards everything.
      do_reset();
      send_frame(8'h42, 1'b1, 1'b0);
      check("prefill_cnt", cnt, 1);
      uart_rx = 1'b0;
      tick(BD);
      for (int i = 0; i < 4; i++) begin
         uart_rx = 1'b1;
         tick(BD);
      end
      tick(H);
      do_reset();
      tick(10 * BD);
      check_status("abort");
      send_frame(8'h81, 1'b1, 1'b0);
      check("after_abort_cnt", cnt, 1);
      req = 1'b1;
      tick(1);
      req = 1'b0;
      check("after_abort_data", rd_data, 8'h81);
      tick(1);

      // Line held low through reset must not start a frame.
      uart_rx = 1'b0;
      do_reset();
      tick(12 * BD);
      check_status("low_at_release");
      uart_rx = 1'b1;
      tick(5);
      send_frame(8'h5A, 1'b1, 1'b0);
      check_status("low_release_frame");
      drain("low_release");

      // Random frames with occasional bad stop bits and random reads.
      for (int r = 0; r < 24; r++) begin
         rb  = 8'($urandom);
         rok = ($urandom_range(0, 4) != 0);
         send_frame(rb, rok, 1'b0);
         check_status("rand_frame");
         if ($urandom_range(0, 2) == 0) begin
            nrd = $urandom_range(1, 6);
            for (int k = 0; k < nrd; k++) begin
               req = 1'($urandom_range(0, 1));
               tick(1);
            end
            req = 1'b0;
            tick(1);
            check_status("rand_read");
         end
      end
      drain("rand");
      check("rand_hold", rd_data, last_exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
